// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging NumPorts request channels onto one memory port.
// An in-order FIFO of granted channel indices routes each response back to its issuer.
module mem_arbiter #(
    parameter int NumPorts       = 2,
    parameter int MaxOutstanding = 4,
    parameter int DataWidth      = 64,
    parameter int MaskBits       = DataWidth / 8
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [NumPorts-1:0]                       req_valid_i,
    output logic [NumPorts-1:0]                       req_ready_o,
    input  logic [NumPorts-1:0][DataWidth-1:0]        req_addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]        req_wdata_i,
    input  logic [NumPorts-1:0][MaskBits-1:0]         req_wmask_i,
    output logic [NumPorts-1:0]                       rsp_rvalid_o,
    output logic [NumPorts-1:0][DataWidth-1:0]        rsp_rdata_o,
    input  logic                                      mem_ready_i,
    output logic                                      mem_valid_o,
    output logic [DataWidth-1:0]                      mem_addr_o,
    output logic [DataWidth-1:0]                      mem_wdata_o,
    output logic [MaskBits-1:0]                       mem_wmask_o,
    input  logic [DataWidth-1:0]                      mem_rdata_i,
    input  logic                                      mem_rvalid_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]       outstanding_o,
    output logic                                      err_o
);

    localparam int PtrW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int FifoW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW  = $clog2(MaxOutstanding + 1);

    logic [PtrW-1:0]  rr_q, rr_d;
    logic [FifoW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             err_q, err_d;
    logic [PtrW-1:0]  fifo_q [MaxOutstanding];

    logic             grant_en;
    logic             gnt_valid;
    logic [PtrW-1:0]  gnt_idx;
    logic [PtrW:0]    cand;
    logic             push_en;
    logic             pop_en;
    logic [PtrW-1:0]  head;

    // Full FIFO blocks grants even when a response frees a slot this cycle.
    assign grant_en = rst_ni && (count_q != CntW'(MaxOutstanding));

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NumPorts; i++) begin
            cand = {1'b0, rr_q} + (PtrW+1)'(i);
            if (cand >= (PtrW+1)'(NumPorts)) begin
                cand = cand - (PtrW+1)'(NumPorts);
            end
            if (grant_en && !gnt_valid && req_valid_i[cand[PtrW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[PtrW-1:0];
            end
        end
    end

    assign push_en     = gnt_valid && mem_ready_i;
    assign pop_en      = mem_rvalid_i && (count_q != '0);
    assign head        = fifo_q[rd_q];
    assign mem_valid_o = gnt_valid;
    assign mem_addr_o  = gnt_valid ? req_addr_i[gnt_idx]  : '0;
    assign mem_wdata_o = gnt_valid ? req_wdata_i[gnt_idx] : '0;
    assign mem_wmask_o = gnt_valid ? req_wmask_i[gnt_idx] : '0;

    always_comb begin
        req_ready_o  = '0;
        rsp_rvalid_o = '0;
        if (push_en) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
        if (pop_en) begin
            rsp_rvalid_o[head] = 1'b1;
        end
        for (int i = 0; i < NumPorts; i++) begin
            rsp_rdata_o[i] = mem_rdata_i;
        end
    end

    always_comb begin
        rr_d    = rr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        err_d   = err_q;
        if (push_en) begin
            rr_d = (gnt_idx == PtrW'(NumPorts - 1)) ? '0 : gnt_idx + PtrW'(1);
            wr_d = (wr_q == FifoW'(MaxOutstanding - 1)) ? '0 : wr_q + FifoW'(1);
        end
        if (pop_en) begin
            rd_d = (rd_q == FifoW'(MaxOutstanding - 1)) ? '0 : rd_q + FifoW'(1);
        end
        if (push_en && !pop_en) begin
            count_d = count_q + CntW'(1);
        end else if (!push_en && pop_en) begin
            count_d = count_q - CntW'(1);
        end
        // A response with nothing in flight is dropped and flagged.
        if (mem_rvalid_i && (count_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            fifo_q[wr_q] <= gnt_idx;
        end
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (3 channels, 4 outstanding): stimulus queues expected
// grants and responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_arbiter;

    localparam int NP = 3;
    localparam int MO = 4;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int CW = 3;

    localparam logic [DW-1:0] ADDR  [NP] = '{32'h0000_0100, 32'h0000_0204, 32'h0000_0308};
    localparam logic [DW-1:0] WDATA [NP] = '{32'h0000_0000, 32'hCAFE_0001, 32'hBEEF_0002};
    localparam logic [MB-1:0] WMASK [NP] = '{4'h0, 4'hF, 4'h3};
    localparam int DRAIN_CH [4] = '{1, 0, 1, 0};

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NP-1:0]           req_valid;
    logic [NP-1:0]           req_ready;
    logic [NP-1:0][DW-1:0]   req_addr;
    logic [NP-1:0][DW-1:0]   req_wdata;
    logic [NP-1:0][MB-1:0]   req_wmask;
    logic [NP-1:0]           rsp_rvalid;
    logic [NP-1:0][DW-1:0]   rsp_rdata;
    logic                    mem_ready;
    logic                    mem_valid;
    logic [DW-1:0]           mem_addr;
    logic [DW-1:0]           mem_wdata;
    logic [MB-1:0]           mem_wmask;
    logic [DW-1:0]           mem_rdata;
    logic                    mem_rvalid;
    logic [CW-1:0]           outstanding;
    logic                    err;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_gnt_q [$];
    int exp_rch_q [$];
    logic [DW-1:0] exp_rdata_q [$];
    int mon_gch;
    int mon_rch;
    logic [DW-1:0] mon_rdata;

    mem_arbiter #(
        .NumPorts(NP), .MaxOutstanding(MO), .DataWidth(DW), .MaskBits(MB)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
        .rsp_rvalid_o(rsp_rvalid), .rsp_rdata_o(rsp_rdata),
        .mem_ready_i(mem_ready), .mem_valid_o(mem_valid),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
        .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid),
        .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid  = '0;
        mem_rvalid = 1'b0;
        mem_ready  = 1'b1;
        mem_rdata  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        to_pos();
        to_pos();
        rst_n = 1'b1;
    endtask

    task automatic exp_rsp(input int ch, input logic [DW-1:0] data);
        exp_rch_q.push_back(ch);
        exp_rdata_q.push_back(data);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
    endtask

    // Monitor: every handshake and every routed response must match the head of its queue.
    always @(negedge clk) begin
        if (mem_valid && mem_ready) begin
            chk("grant_expected", 64'(exp_gnt_q.size() != 0), 64'd1);
            if (exp_gnt_q.size() != 0) begin
                mon_gch = exp_gnt_q.pop_front();
                chk("gnt_ready_onehot", 64'(req_ready), 64'(1) << mon_gch);
                chk("gnt_addr",  64'(mem_addr),  64'(ADDR[mon_gch]));
                chk("gnt_wdata", 64'(mem_wdata), 64'(WDATA[mon_gch]));
                chk("gnt_wmask", 64'(mem_wmask), 64'(WMASK[mon_gch]));
            end
        end
        if (|rsp_rvalid) begin
            chk("rsp_expected", 64'(exp_rch_q.size() != 0), 64'd1);
            if (exp_rch_q.size() != 0) begin
                mon_rch   = exp_rch_q.pop_front();
                mon_rdata = exp_rdata_q.pop_front();
                chk("rsp_onehot", 64'(rsp_rvalid), 64'(1) << mon_rch);
                chk("rsp_data", 64'(rsp_rdata[mon_rch]), 64'(mon_rdata));
            end
        end
    end

    initial begin
        for (int c = 0; c < NP; c++) begin
            req_addr[c]  = ADDR[c];
            req_wdata[c] = WDATA[c];
            req_wmask[c] = WMASK[c];
        end
        idle();
        req_valid = 3'b111;

        // reset state with all channels requesting
        to_neg();
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rsp_rvalid", 64'(rsp_rvalid), 64'd0);
        to_pos();
        idle();
        rst_n = 1'b1;

        // single read on ch0, response two cycles later
        req_valid = 3'b001;
        exp_gnt_q.push_back(0);
        to_neg();
        chk("t1_ready", 64'(req_ready), 64'd1);
        chk("t1_out_c0", 64'(outstanding), 64'd0);
        to_pos();
        req_valid = '0;
        to_neg();
        chk("t1_out_c1", 64'(outstanding), 64'd1);
        to_pos();
        exp_rsp(0, 32'h0000_DEAD);
        to_neg();
        chk("t1_out_c2", 64'(outstanding), 64'd1);
        to_pos();
        idle();
        to_neg();
        chk("t1_out_c3", 64'(outstanding), 64'd0);
        to_pos();

        // full-load round robin, memory answers one cycle after each grant
        do_reset();
        for (int k = 0; k < 7; k++) begin
            req_valid  = (k < 6) ? 3'b111 : 3'b000;
            mem_rvalid = 1'b0;
            if (k < 6) exp_gnt_q.push_back(k % 3);
            if (k > 0) exp_rsp((k - 1) % 3, 32'hA000 + 32'(k - 1));
            to_neg();
            to_pos();
        end
        idle();
        to_neg();
        chk("rr_out_drained", 64'(outstanding), 64'd0);
        to_pos();

        // FIFO full: four grants, then none, a pop in the full cycle does not unblock
        do_reset();
        req_valid = 3'b011;
        for (int k = 0; k < 4; k++) begin
            exp_gnt_q.push_back(k % 2);
            to_neg();
            to_pos();
        end
        to_neg();
        chk("full_no_grant", 64'(mem_valid), 64'd0);
        chk("full_out", 64'(outstanding), 64'd4);
        to_pos();
        exp_rsp(0, 32'hB000);
        to_neg();
        chk("full_pop_no_grant", 64'(mem_valid), 64'd0);
        to_pos();
        mem_rvalid = 1'b0;
        exp_gnt_q.push_back(0);
        to_neg();
        chk("full_regrant", 64'(mem_valid), 64'd1);
        chk("full_out_after_pop", 64'(outstanding), 64'd3);
        to_pos();
        req_valid = '0;
        for (int j = 0; j < 4; j++) begin
            exp_rsp(DRAIN_CH[j], 32'hB001 + 32'(j));
            to_neg();
            to_pos();
        end
        idle();
        to_neg();
        chk("full_drained", 64'(outstanding), 64'd0);
        to_pos();

        // back-pressure: grant holds on ch1 while mem_ready is low
        do_reset();
        req_valid = 3'b001;
        exp_gnt_q.push_back(0);
        to_neg();
        to_pos();
        req_valid = '0;
        exp_rsp(0, 32'h11);
        to_neg();
        to_pos();
        idle();
        req_valid = 3'b010;
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            to_neg();
            chk("bp_valid", 64'(mem_valid), 64'd1);
            chk("bp_ready_low", 64'(req_ready), 64'd0);
            chk("bp_addr_ch1", 64'(mem_addr), 64'(ADDR[1]));
            to_pos();
        end
        req_valid = 3'b011;
        to_neg();
        chk("bp_hold_ch1", 64'(mem_addr), 64'(ADDR[1]));
        to_pos();
        mem_ready = 1'b1;
        exp_gnt_q.push_back(1);
        to_neg();
        to_pos();
        req_valid = 3'b001;
        exp_gnt_q.push_back(0);
        to_neg();
        to_pos();
        req_valid = '0;
        exp_rsp(1, 32'h21);
        to_neg();
        to_pos();
        exp_rsp(0, 32'h22);
        to_neg();
        to_pos();
        idle();

        // stray response sets a sticky error
        do_reset();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD;
        to_neg();
        chk("err_no_rsp", 64'(rsp_rvalid), 64'd0);
        chk("err_same_cycle", 64'(err), 64'd0);
        to_pos();
        mem_rvalid = 1'b0;
        to_neg();
        chk("err_next_cycle", 64'(err), 64'd1);
        to_pos();
        to_pos();
        to_neg();
        chk("err_sticky", 64'(err), 64'd1);
        to_pos();
        rst_n = 1'b0;
        to_neg();
        chk("err_cleared", 64'(err), 64'd0);
        to_pos();
        rst_n = 1'b1;

        // asynchronous reset with two requests in flight
        req_valid = 3'b011;
        exp_gnt_q.push_back(0);
        to_neg();
        to_pos();
        exp_gnt_q.push_back(1);
        to_neg();
        to_pos();
        req_valid = '0;
        to_neg();
        chk("mid_out_two", 64'(outstanding), 64'd2);
        #2;
        rst_n     = 1'b0;
        req_valid = 3'b011;
        #1;
        chk("async_out", 64'(outstanding), 64'd0);
        chk("async_valid", 64'(mem_valid), 64'd0);
        chk("async_ready", 64'(req_ready), 64'd0);
        chk("async_addr", 64'(mem_addr), 64'd0);
        to_pos();
        rst_n = 1'b1;
        exp_gnt_q.push_back(0);
        to_neg();
        chk("resume_ch0", 64'(req_ready), 64'd1);
        to_pos();
        req_valid = '0;
        exp_rsp(0, 32'h77);
        to_neg();
        to_pos();
        idle();
        to_neg();
        chk("resume_out", 64'(outstanding), 64'd0);
        chk("resume_err", 64'(err), 64'd0);
        to_pos();

        chk("grant_queue_empty", 64'(exp_gnt_q.size()), 64'd0);
        chk("rsp_queue_empty", 64'(exp_rch_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
